booth_ppg_32r4: RTL and testbench



---
 rtl/booth_ppg_32r4.sv | 138 +++++++++++++
 tb/tb_booth_ppg_32r4.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/booth_ppg_32r4.sv
// Registered 32x32 radix-4 Booth multiplier front end: partial-product generation,
// a 3:2 compressor tree down to one carry-save pair, and a single output register.
module booth_ppg_32r4 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] mulcand,
    input  logic [31:0] muler,
    input  logic        sign,
    input  logic        in_valid,
    output logic [62:0] C,
    output logic [63:0] S,
    output logic        out_valid
);

    localparam int NUM_ROWS   = 18;
    localparam int NUM_LEVELS = 6;

    logic [33:0] m_ext;
    logic [34:0] y_app;
    logic [63:0] rows [NUM_ROWS];
    logic [63:0] sum_row;
    logic [62:0] carry_row;

    logic [62:0] c_d, c_q;
    logic [63:0] s_d, s_q;
    logic        out_valid_d, out_valid_q;

    // Booth rows carry ~sign at bit 33; the matching -2^(33+2j) terms and the
    // negation bits share row 17 because they never overlap (bits >=33 vs <=30).
    always_comb begin : booth_rows
        logic [2:0]  trip;
        logic        neg;
        logic        one;
        logic        two;
        logic [33:0] sel;
        logic [33:0] pp;
        logic [63:0] neg_row;
        logic [63:0] sign_const;

        m_ext      = {{2{sign & mulcand[31]}}, mulcand};
        y_app      = {{2{sign & muler[31]}}, muler, 1'b0};
        neg_row    = '0;
        sign_const = '0;
        trip       = '0;
        neg        = 1'b0;
        one        = 1'b0;
        two        = 1'b0;
        sel        = '0;
        pp         = '0;

        for (int j = 0; j < 16; j++) begin
            trip = y_app[2*j+2 -: 3];
            neg  = trip[2] & ~(trip[1] & trip[0]);
            one  = trip[1] ^ trip[0];
            two  = (trip == 3'b011) || (trip == 3'b100);
            sel  = one ? m_ext : (two ? {m_ext[32:0], 1'b0} : 34'd0);
            pp   = sel ^ {34{neg}};
            rows[j]    = {30'd0, ~pp[33], pp[32:0]} << (2*j);
            neg_row    = neg_row | ({63'd0, neg} << (2*j));
            sign_const = sign_const - (64'd1 << (33 + 2*j));
        end

        // Top digit is only nonzero for unsigned operands with muler[31] set, and then it is +1.
        rows[16] = (!sign && muler[31]) ? {mulcand, 32'd0} : 64'd0;
        rows[17] = sign_const | neg_row;
    end

    // Wallace-style reduction: each level feeds every complete group of three rows
    // through a 3:2 compressor and passes leftovers straight down (18,12,8,6,4,3,2).
    always_comb begin : csa_tree
        logic [63:0] lvl [NUM_LEVELS+1][NUM_ROWS];
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] c;
        int          n;
        int          groups;

        lvl    = '{default: '0};
        a      = '0;
        b      = '0;
        c      = '0;
        n      = NUM_ROWS;
        groups = 0;

        for (int r = 0; r < NUM_ROWS; r++) begin
            lvl[0][r] = rows[r];
        end

        for (int l = 0; l < NUM_LEVELS; l++) begin
            groups = n / 3;
            for (int g = 0; g < NUM_ROWS / 3; g++) begin
                if (g < groups) begin
                    a = lvl[l][3*g];
                    b = lvl[l][3*g+1];
                    c = lvl[l][3*g+2];
                    lvl[l+1][2*g]   = a ^ b ^ c;
                    lvl[l+1][2*g+1] = ((a & b) | (a & c) | (b & c)) << 1;
                end
            end
            for (int r = 0; r < NUM_ROWS; r++) begin
                if (r >= 3*groups && r < n) begin
                    lvl[l+1][r - groups] = lvl[l][r];
                end
            end
            n = n - groups;
        end

        sum_row   = lvl[NUM_LEVELS][0];
        carry_row = lvl[NUM_LEVELS][1][63:1];
    end

    always_comb begin : next_state
        c_d         = c_q;
        s_d         = s_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            c_d = carry_row;
            s_d = sum_row;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            c_q         <= '0;
            s_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            c_q         <= c_d;
            s_q         <= s_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign C         = c_q;
    assign S         = s_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_booth_ppg_32r4.sv
// Scoreboard bench for booth_ppg_32r4: the driver queues expected products,
// the monitor resolves {C,0}+S whenever out_valid is seen and checks latency, hold and reset.
module tb_booth_ppg_32r4;

    logic        clk;
    logic        rst_n;
    logic [31:0] mulcand;
    logic [31:0] muler;
    logic        sign;
    logic        in_valid;
    logic [62:0] C;
    logic [63:0] S;
    logic        out_valid;

    typedef struct {
        logic [63:0] prod;
        int          cyc;
    } exp_t;

    exp_t        sbQueue[$];
    int          checkCount = 0;
    int          errorCount = 0;
    int          cycleCount = 0;
    logic [62:0] prevC = '0;
    logic [63:0] prevS = '0;

    booth_ppg_32r4 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mulcand   (mulcand),
        .muler     (muler),
        .sign      (sign),
        .in_valid  (in_valid),
        .C         (C),
        .S         (S),
        .out_valid (out_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference product straight from 64-bit integer arithmetic.
    function automatic logic [63:0] refProduct(input logic [31:0] a, input logic [31:0] b,
                                               input logic sgn);
        longint sa;
        longint sb;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        return 64'(sa * sb);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                                 input logic valid, input logic [63:0] expected);
        exp_t e;
        @(negedge clk);
        rst_n    = 1'b1;
        mulcand  = a;
        muler    = b;
        sign     = sgn;
        in_valid = valid;
        if (valid) begin
            e.prod = expected;
            e.cyc  = cycleCount;
            sbQueue.push_back(e);
        end
    endtask

    task automatic applyRandom(input logic valid);
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        a   = $urandom;
        b   = $urandom;
        sgn = 1'($urandom_range(0, 1));
        applyStimulus(a, b, sgn, valid, refProduct(a, b, sgn));
    endtask

    task automatic pulseReset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        mulcand  = $urandom;
        muler    = $urandom;
        sign     = 1'($urandom_range(0, 1));
    endtask

    // Monitor: samples 1 time unit after each rising edge, away from driver activity.
    initial begin : monitor
        exp_t        e;
        logic [63:0] act;
        forever begin
            @(posedge clk);
            #1;
            cycleCount++;
            act = {C, 1'b0} + S;
            if (!rst_n) begin
                checkOutput("reset_c", 64'(C), 64'd0);
                checkOutput("reset_s", S, 64'd0);
                checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
            end else if (out_valid) begin
                if (sbQueue.size() == 0) begin
                    checkCount++;
                    errorCount++;
                    $display("[TB] FAIL unexpected_out_valid: got result 0x%h, expected none", act);
                end else begin
                    e = sbQueue.pop_front();
                    checkOutput("product", act, e.prod);
                    checkOutput("latency", 64'(cycleCount), 64'(e.cyc + 1));
                end
            end else begin
                checkOutput("hold_c", 64'(C), 64'(prevC));
                checkOutput("hold_s", S, prevS);
            end
            prevC = C;
            prevS = S;
        end
    end

    initial begin : watchdog
        #2000000;
        errorCount++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $fatal(1, "[TB] timeout");
    end

    initial begin : driver
        logic [31:0] digitPats [3];
        digitPats[0] = 32'hAAAAAAAA;
        digitPats[1] = 32'h55555555;
        digitPats[2] = 32'h66666666;

        rst_n    = 1'b0;
        in_valid = 1'b1;
        mulcand  = 32'hFFFFFFFF;
        muler    = 32'hFFFFFFFF;
        sign     = 1'b0;
        repeat (3) @(negedge clk);

        applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 64'hFFFFFFFE00000001);
        applyStimulus(32'h80000000, 32'h00000002, 1'b0, 1'b1, 64'h0000000100000000);
        applyStimulus(32'h00000000, 32'h12345678, 1'b0, 1'b1, 64'h0000000000000000);
        applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 64'h0000000000000001);
        applyStimulus(32'h80000000, 32'h80000000, 1'b1, 1'b1, 64'h4000000000000000);
        applyStimulus(32'h80000000, 32'h00000001, 1'b1, 1'b1, 64'hFFFFFFFF80000000);
        applyStimulus(32'h00000007, 32'hFFFFFFFD, 1'b1, 1'b1, 64'hFFFFFFFFFFFFFFEB);

        for (int p = 0; p < 3; p++) begin
            for (int s = 0; s < 2; s++) begin
                applyStimulus(32'h7FFFFFFF, digitPats[p], 1'(s), 1'b1,
                              refProduct(32'h7FFFFFFF, digitPats[p], 1'(s)));
            end
        end

        applyStimulus(32'h0, 32'h0, 1'b0, 1'b0, 64'd0);
        applyStimulus(32'h0, 32'h0, 1'b0, 1'b0, 64'd0);

        for (int i = 0; i < 1000; i++) begin
            applyRandom(1'b1);
        end

        for (int i = 0; i < 3; i++) begin
            applyRandom(1'b0);
        end

        for (int i = 0; i < 200; i++) begin
            if (i == 100) begin
                pulseReset();
            end
            applyRandom(($urandom_range(0, 3) != 0));
        end

        applyStimulus(32'h0, 32'h0, 1'b0, 1'b0, 64'd0);
        repeat (3) @(negedge clk);
        checkOutput("drain", 64'(sbQueue.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
